// File: rtl/noc_params.sv
// Shared NoC parameters and flit types used by the link scheduler and its arbiter.
package noc_params;

    localparam int VC_NUM      = 2;
    localparam int FLIT_DATA_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t              label;
        logic [FLIT_DATA_W-1:0]   data;
    } flit_t;

    function automatic logic is_packet_start(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin search: first requester after ptr_i (wrapping) wins.
module round_robin_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o
);

    int unsigned idx;

    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!gnt_valid_o && req_i[IDX_W'(idx)]) begin
                gnt_o[IDX_W'(idx)] = 1'b1;
                gnt_valid_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_link_scheduler.sv
// Schedules head-of-queue flits from VC_NUM virtual-channel buffers onto one registered link.
// Optional whole-packet link locking is built when PACKET_LOCK_EN is defined.
//
// state  | meaning
// IDLE   | per-flit round-robin; only HEAD/HEADTAIL flits may start a transfer
// LOCKED | link owned by lock_vc until its TAIL flit is popped
module vc_link_scheduler
    import noc_params::*;
#(
    parameter  int VC_NUM = noc_params::VC_NUM,
    localparam int IDX_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             flit_i [VC_NUM],
    input  logic [VC_NUM-1:0] is_empty_i,
    input  logic [VC_NUM-1:0] on_off_i,
    output logic [VC_NUM-1:0] read_o,
    output flit_t             flit_o,
    output logic              valid_flit_o,
    output logic [IDX_W-1:0]  grant_vc_o
);

    logic [VC_NUM-1:0] req;
    logic [VC_NUM-1:0] gnt;
    logic              gnt_valid_raw;
    logic              gnt_valid;
    logic [IDX_W-1:0]  sel_idx;
    flit_t             popped;

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    flit_t             flit_q, flit_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  grant_q, grant_d;

`ifdef PACKET_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] lock_vc_q, lock_vc_d;
`endif

    always_comb begin
        req = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            req[v] = ~is_empty_i[v] & on_off_i[v];
`ifdef PACKET_LOCK_EN
            // While locked, masking requests down to lock_vc makes the pointer irrelevant.
            if (state_q == ST_IDLE) begin
                req[v] = req[v] & is_packet_start(flit_i[v].label);
            end else begin
                req[v] = req[v] & (IDX_W'(v) == lock_vc_q);
            end
`endif
        end
    end

    round_robin_arbiter #(
        .N (VC_NUM)
    ) u_rr_arb (
        .req_i       (req),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid_raw)
    );

    // Buffers must not be popped while reset is held.
    assign gnt_valid = gnt_valid_raw & rst;
    assign read_o    = rst ? gnt : '0;

    always_comb begin
        sel_idx = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (gnt[v]) begin
                sel_idx = IDX_W'(v);
            end
        end
    end

    assign popped = flit_i[sel_idx];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        flit_d   = flit_q;
        grant_d  = grant_q;
        valid_d  = gnt_valid;
        if (gnt_valid) begin
            flit_d  = popped;
            grant_d = sel_idx;
        end
`ifdef PACKET_LOCK_EN
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    if (popped.label == HEAD) begin
                        state_d   = ST_LOCKED;
                        lock_vc_d = sel_idx;
                    end else begin
                        rr_ptr_d = sel_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (gnt_valid && (popped.label == TAIL)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = lock_vc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        if (gnt_valid) begin
            rr_ptr_d = sel_idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= IDX_W'(VC_NUM - 1);
            flit_q   <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            flit_q   <= flit_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
        end
    end

`ifdef PACKET_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end
`endif

    assign flit_o       = flit_q;
    assign valid_flit_o = valid_q;
    assign grant_vc_o   = grant_q;

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Scoreboard bench for vc_link_scheduler: bench-side VC buffers, round-robin reference, link checks.
module tb_vc_link_scheduler;
    import noc_params::*;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    flit_t         flit_i [N];
    logic [N-1:0]  is_empty_i;
    logic [N-1:0]  on_off_i;
    logic [N-1:0]  read_o;
    flit_t         flit_o;
    logic          valid_flit_o;
    logic [0:0]    grant_vc_o;

    always #5 clk = ~clk;

    vc_link_scheduler #(.VC_NUM(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_i       (flit_i),
        .is_empty_i   (is_empty_i),
        .on_off_i     (on_off_i),
        .read_o       (read_o),
        .flit_o       (flit_o),
        .valid_flit_o (valid_flit_o),
        .grant_vc_o   (grant_vc_o)
    );

    typedef struct {
        flit_t       f;
        int unsigned vc;
    } exp_t;

    flit_t       bq [N][$];
    logic [N-1:0] on_v;
    logic [N-1:0] hide_v;
    exp_t        sb [$];
    int unsigned grant_log [$];
    int unsigned m_ptr;
    bit          m_locked;
    int unsigned m_lock_vc;
    flit_t       last_flit;
    int unsigned last_vc;
    int          n_checks;
    int          n_fail;
    int unsigned seq_cnt;

    function automatic flit_t mk(input flit_label_t l, input int unsigned vc);
        flit_t f;
        f.label = l;
        f.data  = 16'((vc << 12) | (seq_cnt & 32'hfff));
        seq_cnt++;
        return f;
    endfunction

    task automatic add_packet(input int unsigned vc, input int unsigned len);
        if (len <= 1) begin
            bq[vc].push_back(mk(HEADTAIL, vc));
        end else begin
            bq[vc].push_back(mk(HEAD, vc));
            for (int k = 0; k < int'(len) - 2; k++) bq[vc].push_back(mk(BODY, vc));
            bq[vc].push_back(mk(TAIL, vc));
        end
    endtask

    task automatic drive();
        for (int v = 0; v < N; v++) begin
            flit_i[v]     = (bq[v].size() > 0) ? bq[v][0] : '0;
            is_empty_i[v] = (bq[v].size() == 0) || hide_v[v];
        end
        on_off_i = on_v;
    endtask

    function automatic void model_sel(output bit found, output int unsigned sel);
        found = 0;
        sel   = 0;
        for (int i = 1; i <= N; i++) begin
            int unsigned v = (m_ptr + i) % N;
            bit e = (bq[v].size() > 0) && !hide_v[v] && on_v[v];
`ifdef PACKET_LOCK_EN
            if (e) begin
                if (m_locked) e = (v == m_lock_vc);
                else          e = (bq[v][0].label == HEAD) || (bq[v][0].label == HEADTAIL);
            end
`endif
            if (e && !found) begin
                found = 1;
                sel   = v;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        exp_t e;
        n_checks++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (valid_flit_o !== 1'b1) begin
                n_fail++;
                $display("FAIL %s valid: got %b want 1", tag, valid_flit_o);
            end
            n_checks++;
            if (flit_o !== e.f || grant_vc_o !== 1'(e.vc)) begin
                n_fail++;
                $display("FAIL %s link flit: got %h vc %0d want %h vc %0d", tag, flit_o, grant_vc_o, e.f, e.vc);
            end
            last_flit = e.f;
            last_vc   = e.vc;
        end else begin
            if (valid_flit_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle valid: got %b want 0", tag, valid_flit_o);
            end
            n_checks++;
            if (flit_o !== last_flit || grant_vc_o !== 1'(last_vc)) begin
                n_fail++;
                $display("FAIL %s hold: got %h vc %0d want %h vc %0d", tag, flit_o, grant_vc_o, last_flit, last_vc);
            end
        end
    endtask

    task automatic select_phase(input string tag);
        bit          found;
        int unsigned sel;
        logic [N-1:0] exp_rd;
        exp_t        e;
        drive();
        #1;
        model_sel(found, sel);
        exp_rd = found ? N'(1 << sel) : '0;
        n_checks++;
        if (read_o !== exp_rd) begin
            n_fail++;
            $display("FAIL %s read_o: got %b want %b", tag, read_o, exp_rd);
        end
        if (found) begin
            e.f  = bq[sel][0];
            e.vc = sel;
            sb.push_back(e);
            grant_log.push_back(sel);
`ifdef PACKET_LOCK_EN
            if (!m_locked) begin
                if (e.f.label == HEAD) begin
                    m_locked  = 1;
                    m_lock_vc = sel;
                end else begin
                    m_ptr = sel;
                end
            end else if (e.f.label == TAIL) begin
                m_locked = 0;
                m_ptr    = m_lock_vc;
            end
`else
            m_ptr = sel;
`endif
            void'(bq[sel].pop_front());
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_outputs(tag);
        select_phase(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        check_outputs(tag);
        rst = 1'b0;
        sb.delete();
        m_ptr     = N - 1;
        m_locked  = 0;
        m_lock_vc = 0;
        last_flit = '0;
        last_vc   = 0;
        drive();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (read_o !== '0 || valid_flit_o !== 1'b0 || flit_o !== '0 || grant_vc_o !== '0) begin
                n_fail++;
                $display("FAIL %s in-reset outputs: read %b valid %b flit %h vc %0d want all 0",
                         tag, read_o, valid_flit_o, flit_o, grant_vc_o);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        select_phase(tag);
    endtask

    task automatic drain(input string tag);
        int budget = 60;
        while ((bq[0].size() > 0 || bq[1].size() > 0 || sb.size() > 0) && budget > 0) begin
            cycle(tag);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL %s drain timeout: got %0d/%0d left want 0", tag, bq[0].size(), bq[1].size());
        end
    endtask

    task automatic test_reset();
        on_v   = '1;
        hide_v = '0;
        add_packet(0, 1);
        add_packet(1, 1);
        do_reset("reset");
        drain("reset");
    endtask

    task automatic test_round_robin();
        do_reset("rr_reset");
        grant_log.delete();
        for (int k = 0; k < 3; k++) begin
            add_packet(0, 1);
            add_packet(1, 1);
        end
        for (int k = 0; k < 7; k++) cycle("rr");
        n_checks++;
        if (grant_log.size() < 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0) begin
            n_fail++;
            $display("FAIL rr order: got %p want 0,1,0,...", grant_log);
        end
        drain("rr");
    endtask

    task automatic test_on_off();
        bit saw0 = 0;
        grant_log.delete();
        on_v = 2'b10;
        for (int k = 0; k < 3; k++) begin
            add_packet(0, 1);
            add_packet(1, 1);
        end
        for (int k = 0; k < 6; k++) cycle("on_off");
        foreach (grant_log[i]) if (grant_log[i] == 0) saw0 = 1;
        n_checks++;
        if (saw0 || grant_log.size() != 3) begin
            n_fail++;
            $display("FAIL on_off grants: got %p want three VC1 grants", grant_log);
        end
        on_v = '1;
        drain("on_off");
    endtask

    task automatic test_all_empty();
        for (int k = 0; k < 5; k++) cycle("empty");
        add_packet(0, 1);
        add_packet(1, 1);
        drain("empty_after");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) add_packet(1, 1);
        for (int k = 0; k < 3; k++) add_packet(0, 1);
        drain("b2b");
    endtask

    task automatic test_reset_mid_packet();
        do_reset("mid_reset_a");
        add_packet(0, 3);
        add_packet(1, 1);
        cycle("mid_pkt");
        do_reset("mid_reset_b");
        for (int k = 0; k < 3; k++) cycle("mid_after");
        bq[0].delete();
        bq[1].delete();
        for (int k = 0; k < 2; k++) cycle("mid_flush");
        do_reset("mid_reset_c");
    endtask

`ifdef PACKET_LOCK_EN
    task automatic test_lock_order();
        do_reset("lock_order");
        grant_log.delete();
        add_packet(0, 3);
        add_packet(1, 1);
        drain("lock_order");
        n_checks++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 0 || grant_log[2] != 0 || grant_log[3] != 1) begin
            n_fail++;
            $display("FAIL lock_order: got %p want 0,0,0,1", grant_log);
        end
    endtask

    task automatic test_lock_stall();
        do_reset("lock_stall");
        grant_log.delete();
        add_packet(0, 3);
        add_packet(1, 1);
        add_packet(1, 1);
        cycle("lock_stall");
        hide_v = 2'b01;
        for (int k = 0; k < 3; k++) cycle("lock_stall_hold");
        hide_v = '0;
        drain("lock_stall");
        n_checks++;
        if (grant_log.size() != 5 || grant_log[0] != 0 || grant_log[1] != 0 || grant_log[2] != 0 ||
            grant_log[3] != 1 || grant_log[4] != 1) begin
            n_fail++;
            $display("FAIL lock_stall order: got %p want 0,0,0,1,1", grant_log);
        end
    endtask
`endif

    task automatic test_random();
        do_reset("rand");
        for (int k = 0; k < 300; k++) begin
            for (int v = 0; v < N; v++) begin
                if (bq[v].size() < 6 && $urandom_range(0, 3) == 0) add_packet(v, $urandom_range(1, 4));
                on_v[v]   = ($urandom_range(0, 4) != 0);
                hide_v[v] = ($urandom_range(0, 6) == 0);
            end
            cycle("rand");
        end
        on_v   = '1;
        hide_v = '0;
        drain("rand");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        seq_cnt   = 1;
        on_v      = '1;
        hide_v    = '0;
        m_ptr     = N - 1;
        m_locked  = 0;
        m_lock_vc = 0;
        last_flit = '0;
        last_vc   = 0;
        rst       = 1'b1;
        drive();
        #2 rst = 1'b0;
        #2;
        test_reset();
        test_round_robin();
        test_on_off();
        test_all_empty();
        test_back_to_back();
        test_reset_mid_packet();
`ifdef PACKET_LOCK_EN
        test_lock_order();
        test_lock_stall();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_link_scheduler.md
VC_LINK_SCHEDULER -- requirements
Module: vc_link_scheduler

Interface
REQ-001 Parameter VC_NUM, default 2, number of virtual-channel buffers sharing one output link.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 flit_i  input  flit_t[VC_NUM]  head-of-queue flit from each VC buffer, combinational from the buffer.
REQ-005 is_empty_i  input  [VC_NUM-1:0]  per-VC buffer empty flag.
REQ-006 on_off_i  input  [VC_NUM-1:0]  downstream on/off flag per VC; 1 = may send.
REQ-007 read_o  output  [VC_NUM-1:0]  one-hot or zero pop strobe to the VC buffers, combinational.
REQ-008 flit_o  output  flit_t  registered flit driven onto the link.
REQ-009 valid_flit_o  output  1  registered; flit_o is valid this cycle.
REQ-010 grant_vc_o  output  [$clog2(VC_NUM)-1:0]  registered index of the VC that sourced flit_o.

Function
REQ-011 A VC is eligible in a cycle if is_empty_i[v]=0 and on_off_i[v]=1.
REQ-012 Each cycle at most one VC is selected; read_o[sel]=1 in that same cycle, all other bits 0.
REQ-013 Selection is round-robin: search starts at (rr_ptr+1) mod VC_NUM, first eligible VC wins.
REQ-014 The popped flit appears on flit_o with valid_flit_o=1 and grant_vc_o=sel exactly one cycle after read_o is asserted (latency 1).
REQ-015 With no selection, next cycle valid_flit_o=0; flit_o and grant_vc_o hold their previous values.
REQ-016 rr_ptr updates to sel on every pop in flit-interleaved mode (REQ-022 off).
REQ-017 Selection never pops a VC with is_empty_i=1 or on_off_i=0, including during a locked packet.
REQ-018 Pointer wrap: after sel=VC_NUM-1 the search starts at VC 0.
REQ-019 on_off_i changes take effect in the same cycle they are presented (no internal registering).

Reset
REQ-020 While rst=0: read_o=0, valid_flit_o=0, flit_o=0, grant_vc_o=0, state=IDLE, rr_ptr=VC_NUM-1 (VC 0 first priority after reset).
REQ-021 Reset asserted mid-packet drops any lock immediately; no flit is emitted in the cycle following reset release unless newly selected.

Configuration
REQ-022 Macro PACKET_LOCK_EN: when defined, the block runs a 2-state FSM (IDLE, LOCKED) holding the link for a whole packet; when undefined, no FSM is built and arbitration is per flit (REQ-016).
REQ-023 With PACKET_LOCK_EN, in IDLE a popped HEAD flit moves state to LOCKED with lock_vc=sel; a popped HEADTAIL flit stays in IDLE and sets rr_ptr=sel.
REQ-024 With PACKET_LOCK_EN, in LOCKED only lock_vc may be selected; if lock_vc is empty or off, nothing is popped and the lock is held (stall).
REQ-025 With PACKET_LOCK_EN, popping a TAIL flit from lock_vc returns to IDLE and sets rr_ptr=lock_vc; the next cycle arbitrates normally.
REQ-026 With PACKET_LOCK_EN, a BODY or TAIL flit at the head of a VC in IDLE is not eligible (protocol error guard).

Structure
REQ-027 flit_t, flit_label_t (HEAD, BODY, TAIL, HEADTAIL) and VC_NUM come from the shared package noc_params; no local redefinition.
REQ-028 Round-robin search is a separate combinational sub-module round_robin_arbiter (inputs: request vector, pointer; outputs: grant one-hot, grant valid).

Verification
REQ-029 Reset release, VC0 and VC1 both non-empty and on, HEADTAIL flits -> read_o=01 cycle 1, 10 cycle 2, 01 cycle 3; flit_o follows one cycle later with grant_vc_o 0,1,0.
REQ-030 VC0 on_off_i=0, VC1 eligible -> read_o never has bit 0 set; only VC1 flits on link.
REQ-031 PACKET_LOCK_EN: VC0 holds HEAD,BODY,TAIL, VC1 holds HEADTAIL -> link order VC0 H,B,T then VC1 HT; no interleave.
REQ-032 PACKET_LOCK_EN: VC0 locked after HEAD, VC0 goes empty for 3 cycles while VC1 non-empty -> read_o=00 for 3 cycles, valid_flit_o=0, lock held, then VC0 BODY resumes.
REQ-033 Reset asserted during LOCKED -> next cycle after release, VC1 HEADTAIL granted before VC0 remainder if rr ordering dictates (rr_ptr=VC_NUM-1, VC0 first); all outputs 0 during reset.
REQ-034 All VCs empty for 5 cycles -> read_o=0 and valid_flit_o=0 throughout; rr_ptr unchanged.
